// File: rtl/simple_bus_pkg.sv
// Shared types and default parameters for the simple_bus follower.
package simple_bus_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_READ_WAIT  = 2;

  typedef enum logic [1:0] {
    StIdle,
    StAddrLo,
    StReadWait,
    StWriteWait
  } state_e;

endpackage

// File: rtl/simple_bus_mem.sv
// Word-addressed storage: one synchronous write port, one asynchronous read port.
module simple_bus_mem #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Power-up contents are zero; reset deliberately leaves them untouched.
  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1] = '{default: '0};

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/simple_bus.sv
// Bus follower: two-phase address capture, then a timed read or a strobed write.
module simple_bus
  import simple_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned READ_WAIT  = DEFAULT_READ_WAIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  read,
  input  logic [7:0]            address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_oe,
  output logic                  data_valid_out,
  output logic                  data_valid_oe
);

  localparam int unsigned CntWidth = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;

  state_e                state_q, state_d;
  logic [7:0]            addr_hi_q, addr_lo_q;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic                  read_done;

  assign mem_addr  = ADDR_WIDTH'({addr_hi_q, addr_lo_q});
  assign read_done = (cnt_q == CntWidth'(READ_WAIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_hi_q <= '0;
      addr_lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && start) begin
        addr_hi_q <= address;
      end
      if (state_q == StAddrLo) begin
        addr_lo_q <= address;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    mem_we         = 1'b0;
    data_oe        = 1'b0;
    data_valid_out = 1'b0;
    data_valid_oe  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAddrLo;
        end
      end
      StAddrLo: begin
        state_d = read ? StReadWait : StWriteWait;
      end
      StReadWait: begin
        data_valid_oe = 1'b1;
        if (read_done) begin
          data_valid_out = 1'b1;
          data_oe        = 1'b1;
          state_d        = StIdle;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StWriteWait: begin
        if (data_valid_in) begin
          // A reset on the same edge aborts the write.
          mem_we  = !reset;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  simple_bus_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clock(clock),
    .we   (mem_we),
    .waddr(mem_addr),
    .wdata(data_in),
    .raddr(mem_addr),
    .rdata(data_out)
  );

endmodule

// File: tb/tb_simple_bus.sv
// Scoreboard bench for simple_bus: stimulus queues expected reads, a monitor checks them.
module tb_simple_bus;

  localparam int unsigned RW = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       read;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       data_valid_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       data_valid_out;
  logic       data_valid_oe;

  simple_bus dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .read          (read),
    .address       (address),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .data_out      (data_out),
    .data_oe       (data_oe),
    .data_valid_out(data_valid_out),
    .data_valid_oe (data_valid_oe)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops an expectation whenever the follower strobes read data.
  always @(negedge clock) begin
    if (mon_en) begin
      check("oe_tracks_valid", {31'd0, data_oe}, {31'd0, data_valid_out});
      if (data_valid_out) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got data %0h, expected no strobe (cycle %0d)",
                   data_out, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("read_data", {24'd0, data_out}, {24'd0, e.data});
          check("read_cycle", cyc, e.at);
          check("read_valid_oe", {31'd0, data_valid_oe}, 32'd1);
        end
      end
    end
  end

  task automatic check_idle(input string name);
    check({name, "_dvoe"}, {31'd0, data_valid_oe}, 32'd0);
    check({name, "_dvo"}, {31'd0, data_valid_out}, 32'd0);
    check({name, "_oe"}, {31'd0, data_oe}, 32'd0);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] exp, input bit start_in_lo);
    start   = 1'b1;
    address = a[15:8];
    tick();
    start   = start_in_lo;
    read    = 1'b1;
    address = a[7:0];
    tick();
    start = 1'b0;
    read  = 1'b0;
    sb.push_back('{exp, cyc + RW});
    for (int i = 0; i <= RW; i++) begin
      check("rw_valid_oe", {31'd0, data_valid_oe}, 32'd1);
      if (i < RW) check("rw_early_valid", {31'd0, data_valid_out}, 32'd0);
      tick();
    end
    check_idle("after_read");
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int holds,
                          input logic [7:0] old);
    start   = 1'b1;
    address = a[15:8];
    tick();
    start   = 1'b0;
    read    = 1'b0;
    address = a[7:0];
    tick();
    for (int i = 0; i < holds; i++) begin
      data_in       = ~d;
      data_valid_in = 1'b0;
      check("ww_valid_oe", {31'd0, data_valid_oe}, 32'd0);
      check("ww_oe", {31'd0, data_oe}, 32'd0);
      check("no_early_write", {24'd0, dut.u_mem.mem[a]}, {24'd0, old});
      tick();
    end
    data_in       = d;
    data_valid_in = 1'b1;
    check("ww_valid_oe", {31'd0, data_valid_oe}, 32'd0);
    tick();
    data_valid_in = 1'b0;
    check_idle("after_write");
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    read          = 1'b0;
    address       = 8'h00;
    data_in       = 8'h00;
    data_valid_in = 1'b0;
    repeat (2) tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    check_idle("reset");

    do_write(16'h0406, 8'hDC, 0, 8'h00);
    do_read(16'h0406, 8'hDC, 1'b0);
    do_write(16'h0407, 8'hAB, 0, 8'h00);
    do_read(16'h0406, 8'hDC, 1'b0);
    do_read(16'h0407, 8'hAB, 1'b0);
    do_read(16'h1234, 8'h00, 1'b0);

    // Write strobe withheld for five cycles.
    do_write(16'h2000, 8'h77, 5, 8'h00);
    do_read(16'h2000, 8'h77, 1'b0);
    do_read(16'h2001, 8'h00, 1'b0);

    // Reset coinciding with the write strobe must not write.
    start   = 1'b1;
    address = 8'h04;
    tick();
    start   = 1'b0;
    read    = 1'b0;
    address = 8'h07;
    tick();
    data_in       = 8'hEE;
    data_valid_in = 1'b1;
    reset         = 1'b1;
    tick();
    reset         = 1'b0;
    data_valid_in = 1'b0;
    check_idle("write_abort");
    do_read(16'h0407, 8'hAB, 1'b0);

    // Reset in the middle of READ_WAIT aborts without a data strobe.
    start   = 1'b1;
    address = 8'h04;
    tick();
    start   = 1'b0;
    read    = 1'b1;
    address = 8'h06;
    tick();
    read = 1'b0;
    tick();
    check("rw_before_reset", {31'd0, data_valid_oe}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("read_abort");
    tick();
    check_idle("read_abort_hold");

    // start held high during the lower-address phase is ignored.
    do_read(16'h0406, 8'hDC, 1'b1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_reads: got %0d outstanding, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
